// File: rtl/txpippm_step_scheduler_if.sv
// ----------------------------------------------------------------------------
// txpippm_step_scheduler_if
// Command bus between the control/register logic (master) and the TX PI PPM
// step scheduler (slave).
//   cmd_valid    master -> slave  command valid
//   cmd_ready    slave  -> master scheduler can take a command
//   cmd_offset   master -> slave  signed total PI steps (+ = increment)
//   cmd_interval master -> slave  low-gap cycles between pulses
//   abort        master -> slave  stop the running sequence at the next safe point
// ----------------------------------------------------------------------------
interface txpippm_step_scheduler_if #(
  parameter int OFFSET_W   = 16,
  parameter int INTERVAL_W = 16
);
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic signed [OFFSET_W-1:0]   cmd_offset;
  logic        [INTERVAL_W-1:0] cmd_interval;
  logic                         abort;

  modport master (
    output cmd_valid,
    output cmd_offset,
    output cmd_interval,
    output abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_offset,
    input  cmd_interval,
    input  abort,
    output cmd_ready
  );
endinterface

// File: rtl/txpippm_step_scheduler.sv
// ----------------------------------------------------------------------------
// txpippm_step_scheduler
// Producer side of the TX PI PPM controller interface (TXUSRCLK domain).
// Splits a signed phase-offset command into a train of pulse/stepsize requests,
// each at most MAX_STEP steps, separated by a programmable low gap, and keeps a
// running (wrapping) total of all applied steps.
//
// Ports
//   gtwiz_userclk_tx_usrclk_in  clock
//   reset                       synchronous, active-high
//   cmd                         command bus (slave side): valid/ready/offset/
//                               interval/abort
//   pulse_out                   request pulse to the controller, PULSE_CYC wide
//   stepsize_out                [4] direction (1 inc, 0 dec), [3:0] magnitude
//   busy_out                    sequence in progress (PULSE or GAP)
//   done_out                    1-cycle strobe when a sequence ends
//   aborted_out                 qualifies done_out: sequence ended by abort
//   phase_acc_out               signed cumulative applied steps (wraps)
// ----------------------------------------------------------------------------
module txpippm_step_scheduler #(
  parameter int OFFSET_W   = 16,
  parameter int INTERVAL_W = 16,
  parameter int ACC_W      = 24,
  parameter int MAX_STEP   = 15,
  parameter int PULSE_CYC  = 2,
  parameter int MIN_GAP    = 4
) (
  input  logic                    gtwiz_userclk_tx_usrclk_in,
  input  logic                    reset,
  txpippm_step_scheduler_if.slave cmd,
  output logic                    pulse_out,
  output logic [4:0]              stepsize_out,
  output logic                    busy_out,
  output logic                    done_out,
  output logic                    aborted_out,
  output logic signed [ACC_W-1:0] phase_acc_out
);

  // One extra bit so that |most-negative offset| is representable.
  localparam int REM_W = OFFSET_W + 1;

  localparam logic [INTERVAL_W-1:0] MIN_GAP_C    = INTERVAL_W'(MIN_GAP);
  localparam logic [INTERVAL_W-1:0] PULSE_LAST_C = INTERVAL_W'(PULSE_CYC - 1);
  localparam logic [INTERVAL_W-1:0] ONE_C        = INTERVAL_W'(1);
  localparam logic [REM_W-1:0]      MAX_STEP_C   = REM_W'(MAX_STEP);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                    state_reg, state_next;
  logic signed [REM_W-1:0]   rem_reg, rem_next;
  logic [INTERVAL_W-1:0]     gap_reg, gap_next;
  logic [INTERVAL_W-1:0]     cnt_reg, cnt_next;
  logic                      abort_pend_reg, abort_pend_next;
  logic [4:0]                stepsize_reg, stepsize_next;
  logic signed [ACC_W-1:0]   acc_reg, acc_next;
  logic                      pulse_reg, busy_reg, ready_reg, done_reg;
  logic                      aborted_reg, aborted_next;

  // --------------------------------------------------------------------------
  // Step datapath. The value being split is the fresh command on acceptance,
  // otherwise the remaining count; both paths share one magnitude clamp.
  // --------------------------------------------------------------------------
  logic                    accept;
  logic signed [REM_W-1:0] step_src;
  logic [REM_W-1:0]        step_abs;
  logic [3:0]              step_mag;
  logic                    step_inc;
  logic signed [REM_W-1:0] mag_rem;
  logic signed [REM_W-1:0] delta_rem;
  logic signed [ACC_W-1:0] mag_acc;
  logic signed [ACC_W-1:0] delta_acc;
  logic                    abort_eff;
  logic                    issue;

  assign accept    = cmd.cmd_valid & ready_reg;
  assign step_src  = accept ? $signed({cmd.cmd_offset[OFFSET_W-1], cmd.cmd_offset})
                            : rem_reg;
  assign step_abs  = step_src[REM_W-1] ? $unsigned(-step_src) : $unsigned(step_src);
  assign step_mag  = (step_abs > MAX_STEP_C) ? 4'(MAX_STEP) : step_abs[3:0];
  // Only consulted when step_src is non-zero, so "not negative" means "> 0".
  assign step_inc  = ~step_src[REM_W-1];
  assign mag_rem   = $signed({{(REM_W-4){1'b0}}, step_mag});
  assign delta_rem = step_inc ? mag_rem : -mag_rem;
  assign mag_acc   = $signed({{(ACC_W-4){1'b0}}, step_mag});
  assign delta_acc = step_inc ? mag_acc : -mag_acc;

  // An abort seen this cycle counts as pending, so a request arriving in the
  // last gap cycle still ends the sequence there.
  assign abort_eff = abort_pend_reg | cmd.abort;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    rem_next        = rem_reg;
    gap_next        = gap_reg;
    cnt_next        = cnt_reg;
    abort_pend_next = abort_pend_reg;
    stepsize_next   = stepsize_reg;
    acc_next        = acc_reg;
    aborted_next    = 1'b0;
    issue           = 1'b0;

    case (state_reg)
      // DONE lasts one cycle but can take a new command exactly like IDLE.
      ST_IDLE, ST_DONE: begin
        abort_pend_next = 1'b0;
        state_next      = ST_IDLE;
        if (accept) begin
          gap_next = (cmd.cmd_interval < MIN_GAP_C) ? MIN_GAP_C : cmd.cmd_interval;
          rem_next = step_src;
          if (step_src == '0) begin
            state_next = ST_DONE;
          end else begin
            issue = 1'b1;
          end
        end
      end

      ST_PULSE: begin
        abort_pend_next = abort_eff;
        if (cnt_reg == '0) begin
          state_next = ST_GAP;
          cnt_next   = gap_reg - ONE_C;
        end else begin
          cnt_next = cnt_reg - ONE_C;
        end
      end

      ST_GAP: begin
        abort_pend_next = abort_eff;
        if (cnt_reg == '0) begin
          if ((rem_reg != '0) && !abort_eff) begin
            issue = 1'b1;
          end else begin
            state_next   = ST_DONE;
            aborted_next = abort_eff;
          end
        end else begin
          cnt_next = cnt_reg - ONE_C;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Launch a request: stepsize, remaining and accumulator all move on the
    // same edge that raises pulse_out.
    if (issue) begin
      state_next    = ST_PULSE;
      cnt_next      = PULSE_LAST_C;
      rem_next      = step_src - delta_rem;
      stepsize_next = {step_inc, step_mag};
      acc_next      = acc_reg + delta_acc;
    end
  end

  // --------------------------------------------------------------------------
  // State and output registers. Status outputs are registered from the next
  // state so that every output reads 0 while reset is held.
  // --------------------------------------------------------------------------
  always_ff @(posedge gtwiz_userclk_tx_usrclk_in) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      rem_reg        <= '0;
      gap_reg        <= '0;
      cnt_reg        <= '0;
      abort_pend_reg <= 1'b0;
      stepsize_reg   <= '0;
      acc_reg        <= '0;
      pulse_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      ready_reg      <= 1'b0;
      done_reg       <= 1'b0;
      aborted_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      rem_reg        <= rem_next;
      gap_reg        <= gap_next;
      cnt_reg        <= cnt_next;
      abort_pend_reg <= abort_pend_next;
      stepsize_reg   <= stepsize_next;
      acc_reg        <= acc_next;
      pulse_reg      <= (state_next == ST_PULSE);
      busy_reg       <= (state_next == ST_PULSE) || (state_next == ST_GAP);
      ready_reg      <= (state_next == ST_IDLE) || (state_next == ST_DONE);
      done_reg       <= (state_next == ST_DONE);
      aborted_reg    <= aborted_next;
    end
  end

  assign cmd.cmd_ready  = ready_reg;
  assign pulse_out      = pulse_reg;
  assign stepsize_out   = stepsize_reg;
  assign busy_out       = busy_reg;
  assign done_out       = done_reg;
  assign aborted_out    = aborted_reg;
  assign phase_acc_out  = acc_reg;

endmodule
